hack_cpu_ctrl: RTL and testbench

Multi-cycle control and register core that drives the 16-bit Hack ALU, i.e. the initiator side of the ALU control interface.
- Fetches Hack instructions over a req/ack instruction port.
- Decodes each one into ALU operands and the six ALU control bits (zx, nx, zy, ny, f, no).
- Samples the ALU result and updates the A, D and PC registers.
- Performs data-memory reads and writes over a req/ack data port.
- Sits between the ALU and the memory/bus fabric.

---
 rtl/hack_cpu_ctrl.sv | 105 ++++++++++
 tb/tb_hack_cpu_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/hack_cpu_ctrl.sv
// hack_cpu_ctrl: multi-cycle Hack CPU control core driving an external ALU over req/ack memory ports.
// Optional HACK_CPU_CTRL_RETIRE_CNT_EN adds a 32-bit retired-instruction counter output.
module hack_cpu_ctrl #(
  parameter int PC_W = 15,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [15:0]     imem_data,
  output logic            dmem_rd,
  output logic            dmem_wr,
  output logic [14:0]     dmem_addr,
  output logic [15:0]     dmem_wdata,
  input  logic            dmem_ack,
  input  logic [15:0]     dmem_rdata,
  output logic [15:0]     alu_x,
  output logic [15:0]     alu_y,
  output logic            alu_zx,
  output logic            alu_nx,
  output logic            alu_zy,
  output logic            alu_ny,
  output logic            alu_f,
  output logic            alu_no,
  input  logic [15:0]     alu_out,
  output logic [PC_W-1:0] pc,
  output logic [15:0]     a_reg,
  output logic [15:0]     d_reg
`ifdef HACK_CPU_CTRL_RETIRE_CNT_EN
  ,
  output logic [31:0]     retire_cnt
`endif
);
  typedef enum logic [1:0] {FETCH, LOAD, EXEC, STORE} state_t;
  state_t state, state_n;
  logic run, exec, zr, ng, take, unused_bits;
  logic [15:0] ir, m, wdata;
  logic [14:0] old_a;
  logic [PC_W-1:0] pc_inc;
  assign exec = state == EXEC;
  assign {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no} = exec ? ir[11:6] : 6'b0;
  assign alu_x = d_reg;
  assign alu_y = ir[12] ? m : a_reg;
  assign zr = alu_out == 16'h0;
  assign ng = alu_out[15];
  assign take = (ir[2] & ng) | (ir[1] & zr) | (ir[0] & ~ng & ~zr);
  assign pc_inc = pc + PC_W'(1);
  // run holds requests low for the first cycle so a fetch never rises on reset release
  assign imem_req = run && state == FETCH;
  assign imem_addr = pc;
  assign dmem_rd = state == LOAD;
  assign dmem_wr = state == STORE;
  assign dmem_addr = old_a;
  assign dmem_wdata = wdata;
  assign unused_bits = ^ir[14:13];
  always_comb begin
    state_n = state;
    case (state)
      FETCH: if (run && imem_ack) state_n = (imem_data[15] && imem_data[12]) ? LOAD : EXEC;
      LOAD:  if (dmem_ack) state_n = EXEC;
      EXEC:  state_n = (ir[15] && ir[3]) ? STORE : FETCH;
      STORE: if (dmem_ack) state_n = FETCH;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FETCH;
      run   <= 1'b0;
      pc    <= RESET_PC;
      a_reg <= '0;
      d_reg <= '0;
      ir    <= '0;
      m     <= '0;
      old_a <= '0;
      wdata <= '0;
    end else begin
      state <= state_n;
      run   <= 1'b1;
      if (state == FETCH && run && imem_ack) begin
        ir    <= imem_data;
        old_a <= a_reg[14:0];
      end
      if (state == LOAD && dmem_ack) m <= dmem_rdata;
      if (exec && !ir[15]) begin
        a_reg <= ir;
        pc    <= pc_inc;
      end
      // jump target is A before this instruction's own A write lands
      if (exec && ir[15]) begin
        if (ir[5]) a_reg <= alu_out;
        if (ir[4]) d_reg <= alu_out;
        if (ir[3]) wdata <= alu_out;
        pc <= take ? a_reg[PC_W-1:0] : pc_inc;
      end
    end
  end
`ifdef HACK_CPU_CTRL_RETIRE_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) retire_cnt <= '0;
    else if ((exec && !(ir[15] && ir[3])) || (state == STORE && dmem_ack)) retire_cnt <= retire_cnt + 32'd1;
  end
`endif
endmodule

// File: tb/tb_hack_cpu_ctrl.sv
// tb_hack_cpu_ctrl: scoreboard bench running a directed Hack program against hack_cpu_ctrl with a modelled ALU and memories.
module tb_hack_cpu_ctrl;
  logic clk = 1'b0, rst_n = 1'b0;
  logic imem_req, imem_ack, dmem_rd, dmem_wr, dmem_ack;
  logic [14:0] imem_addr, dmem_addr, pc;
  logic [15:0] imem_data, dmem_wdata, dmem_rdata, alu_x, alu_y, alu_out, a_reg, d_reg;
  logic alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no;
  logic chk_on = 1'b0, hold_imem = 1'b0;
  int tests = 0, fails = 0;

  typedef struct packed {logic [14:0] addr; logic [15:0] a; logic [15:0] d;} fexp_t;
  typedef struct packed {logic wr; logic [14:0] addr; logic [15:0] wdata; int cyc;} dexp_t;
  typedef struct packed {logic [5:0] ctl; logic [15:0] x; logic [15:0] y;} aexp_t;
  fexp_t fq[$];
  dexp_t dq[$];
  aexp_t aq[$];

  always #5 clk = ~clk;

  hack_cpu_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
    .dmem_rd(dmem_rd), .dmem_wr(dmem_wr), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .alu_x(alu_x), .alu_y(alu_y), .alu_zx(alu_zx), .alu_nx(alu_nx), .alu_zy(alu_zy),
    .alu_ny(alu_ny), .alu_f(alu_f), .alu_no(alu_no), .alu_out(alu_out),
    .pc(pc), .a_reg(a_reg), .d_reg(d_reg)
  );

  always_comb begin
    logic [15:0] x, y, r;
    x = alu_zx ? 16'h0 : alu_x;
    x = alu_nx ? ~x : x;
    y = alu_zy ? 16'h0 : alu_y;
    y = alu_ny ? ~y : y;
    r = alu_f ? x + y : x & y;
    alu_out = alu_no ? ~r : r;
  end

  function automatic logic [15:0] prog(input logic [14:0] ad);
    case (ad)
      15'd0: prog = 16'h0005;   15'd1: prog = 16'hEC10;   15'd2: prog = 16'h0007;
      15'd3: prog = 16'hEC10;   15'd4: prog = 16'h0010;   15'd5: prog = 16'hE308;
      15'd6: prog = 16'h0020;   15'd7: prog = 16'hFC10;   15'd8: prog = 16'h0100;
      15'd9: prog = 16'hEE90;   15'd10: prog = 16'hE301;  15'd11: prog = 16'h0003;
      15'd12: prog = 16'hEC10;  15'd13: prog = 16'h0100;  15'd14: prog = 16'hE301;
      15'h100: prog = 16'h0200; 15'h101: prog = 16'hEA87;
      15'h200: prog = 16'h0200; 15'h201: prog = 16'hEA87;
      default: prog = 16'h0000;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic pf(input logic [14:0] ad, input logic [15:0] a, input logic [15:0] d);
    fq.push_back('{ad, a, d});
  endtask

  task automatic pa(input logic [5:0] ctl, input logic [15:0] x, input logic [15:0] y);
    aq.push_back('{ctl, x, y});
  endtask

  task automatic wait_empty(input int lim);
    int n = 0;
    while ((fq.size() != 0 || aq.size() != 0 || dq.size() != 0) && n < lim) begin
      @(negedge clk); #2;
      n++;
    end
    if (fq.size() != 0 || aq.size() != 0 || dq.size() != 0) begin
      tests++; fails++;
      $display("FAIL timeout: queues fetch=%0d alu=%0d dmem=%0d still pending", fq.size(), aq.size(), dq.size());
    end
  endtask

  initial begin : imem_resp
    int c;
    c = 0; imem_ack = 1'b0; imem_data = '0;
    forever begin
      @(negedge clk);
      if (imem_req && !hold_imem) begin
        if (c >= ((imem_addr == 15'd2) ? 1 : (imem_addr == 15'h100) ? 2 : 0)) begin
          imem_ack = 1'b1; imem_data = prog(imem_addr); c = 0;
        end else begin
          imem_ack = 1'b0; c++;
        end
      end else begin
        imem_ack = 1'b0; c = 0;
      end
    end
  end

  initial begin : dmem_resp
    int c;
    c = 0; dmem_ack = 1'b0; dmem_rdata = '0;
    forever begin
      @(negedge clk);
      if (dmem_rd || dmem_wr) begin
        if (c >= (dmem_wr ? 2 : 0)) begin
          dmem_ack = 1'b1; dmem_rdata = (dmem_addr == 15'h20) ? 16'h1234 : 16'h0; c = 0;
        end else begin
          dmem_ack = 1'b0; c++;
        end
      end else begin
        dmem_ack = 1'b0; c = 0;
      end
    end
  end

  initial begin : mon
    logic in_exec;
    logic [15:0] lir;
    logic [14:0] daddr0;
    int dcyc;
    aexp_t ae; fexp_t fe; dexp_t de;
    in_exec = 1'b0; lir = '0; dcyc = 0; daddr0 = '0;
    forever begin
      @(negedge clk); #1;
      if (!rst_n) begin
        in_exec = 1'b0; dcyc = 0;
      end else begin
        if (in_exec && lir[15] && chk_on) begin
          if (aq.size() == 0) begin
            tests++; fails++;
            $display("FAIL alu_extra: unexpected EXEC of %h", lir);
          end else begin
            ae = aq.pop_front();
            chk("alu_ctl", {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no}, ae.ctl);
            chk("alu_x", alu_x, ae.x);
            chk("alu_y", alu_y, ae.y);
          end
        end else if (!in_exec) chk("alu_idle_ctl", {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no}, 0);
        in_exec = 1'b0;
        if (imem_req && imem_ack) begin
          lir = imem_data;
          in_exec = !(imem_data[15] && imem_data[12]);
          if (chk_on) begin
            if (fq.size() == 0) begin
              tests++; fails++;
              $display("FAIL fetch_extra: unexpected fetch at %h", imem_addr);
            end else begin
              fe = fq.pop_front();
              chk("imem_addr", imem_addr, fe.addr);
              chk("pc", pc, fe.addr);
              chk("a_reg", a_reg, fe.a);
              chk("d_reg", d_reg, fe.d);
            end
          end
        end
        if (dmem_rd || dmem_wr) begin
          dcyc++;
          if (dcyc == 1) daddr0 = dmem_addr;
          if (dmem_ack) begin
            if (dmem_rd) in_exec = 1'b1;
            if (dq.size() == 0) begin
              tests++; fails++;
              $display("FAIL dmem_extra: unexpected access at %h", dmem_addr);
            end else begin
              de = dq.pop_front();
              chk("dmem_wr", dmem_wr, de.wr);
              chk("dmem_addr", dmem_addr, de.addr);
              chk("dmem_addr_first", daddr0, de.addr);
              chk("dmem_req_cycles", dcyc, de.cyc);
              if (de.wr) chk("dmem_wdata", dmem_wdata, de.wdata);
            end
            dcyc = 0;
          end
        end
      end
    end
  end

  initial begin
    pf(15'd0, 16'h0000, 16'h0000);   pf(15'd1, 16'h0005, 16'h0000);
    pf(15'd2, 16'h0005, 16'h0005);   pf(15'd3, 16'h0007, 16'h0005);
    pf(15'd4, 16'h0007, 16'h0007);   pf(15'd5, 16'h0010, 16'h0007);
    pf(15'd6, 16'h0010, 16'h0007);   pf(15'd7, 16'h0020, 16'h0007);
    pf(15'd8, 16'h0020, 16'h1234);   pf(15'd9, 16'h0100, 16'h1234);
    pf(15'd10, 16'h0100, 16'hFFFF);  pf(15'd11, 16'h0100, 16'hFFFF);
    pf(15'd12, 16'h0003, 16'hFFFF);  pf(15'd13, 16'h0003, 16'h0003);
    pf(15'd14, 16'h0100, 16'h0003);  pf(15'h100, 16'h0100, 16'h0003);
    pf(15'h101, 16'h0200, 16'h0003); pf(15'h200, 16'h0200, 16'h0003);
    pf(15'h201, 16'h0200, 16'h0003); pf(15'h200, 16'h0200, 16'h0003);
    pf(15'h201, 16'h0200, 16'h0003);
    pa(6'b110000, 16'h0000, 16'h0005); pa(6'b110000, 16'h0005, 16'h0007);
    pa(6'b001100, 16'h0007, 16'h0010); pa(6'b110000, 16'h0007, 16'h1234);
    pa(6'b111010, 16'h1234, 16'h0100); pa(6'b001100, 16'hFFFF, 16'h0100);
    pa(6'b110000, 16'hFFFF, 16'h0003); pa(6'b001100, 16'h0003, 16'h0100);
    pa(6'b101010, 16'h0003, 16'h0200); pa(6'b101010, 16'h0003, 16'h0200);
    pa(6'b101010, 16'h0003, 16'h0200);
    dq.push_back('{1'b1, 15'h0010, 16'h0007, 3});
    dq.push_back('{1'b0, 15'h0020, 16'h0000, 1});
    #3;
    chk("rst_imem_req", imem_req, 0);
    chk("rst_dmem_req", {dmem_rd, dmem_wr}, 0);
    chk("rst_pc", pc, 0);
    chk("rst_a", a_reg, 0);
    chk("rst_d", d_reg, 0);
    chk_on = 1'b1;
    #9 rst_n = 1'b1;
    wait_empty(400);
    chk_on = 1'b0;
    hold_imem = 1'b1;
    begin
      int n = 0;
      do begin
        @(negedge clk); #2;
        n++;
      end while (!imem_req && n < 20);
    end
    chk("hold_imem_req", imem_req, 1);
    chk("hold_pc", pc, 15'h200);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_imem_req", imem_req, 0);
    chk("async_rst_pc", pc, 0);
    chk("async_rst_a", a_reg, 0);
    chk("async_rst_d", d_reg, 0);
    @(negedge clk); #1;
    chk("in_rst_imem_req", imem_req, 0);
    pf(15'd0, 16'h0000, 16'h0000);
    pf(15'd1, 16'h0005, 16'h0000);
    pa(6'b110000, 16'h0000, 16'h0005);
    hold_imem = 1'b0;
    chk_on = 1'b1;
    #2 rst_n = 1'b1;
    wait_empty(100);
    chk_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
